// File: rtl/chan_packetizer_if.sv
// Port bundle for chan_packetizer: sample input side plus the framed TX stream and status.
// The master modport is the packetizer's view; slave is the source/sink side.
interface chan_packetizer_if #(
  parameter int NCHAN    = 2,
  parameter int SAMPLE_W = 16,
  parameter int WORD_W   = 64
);
  logic                      ce;
  logic                      sync;
  logic [NCHAN*SAMPLE_W-1:0] din;
  logic                      tx_ready;
  logic [WORD_W-1:0]         tx_data;
  logic                      tx_valid;
  logic                      tx_eod;
  logic                      overflow;
  logic [15:0]               drop_count;

  modport master (
    input  ce, sync, din, tx_ready,
    output tx_data, tx_valid, tx_eod, overflow, drop_count
  );

  modport slave (
    output ce, sync, din, tx_ready,
    input  tx_data, tx_valid, tx_eod, overflow, drop_count
  );
endinterface

// File: rtl/chan_packetizer.sv
// N-channel packetizer: packs samples into words, buffers whole frames per channel and
// emits header + ch0..chN-1 payload with backpressure and frame-granular overflow drop.
module chan_packetizer #(
  parameter int NCHAN    = 2,
  parameter int SAMPLE_W = 16,
  parameter int WORD_W   = 64,
  parameter int SPP      = 512,
  parameter int DEPTH    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  chan_packetizer_if.master bus
);
  localparam int K    = WORD_W / SAMPLE_W;
  localparam int NFR  = DEPTH / SPP;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW   = (K > 1) ? $clog2(K) : 1;
  localparam int FW   = $clog2(SPP);
  localparam int CW   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int IW   = (NFR > 1) ? $clog2(NFR) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int RDYW = $clog2(NFR + 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} tx_state_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [IW-1:0] id_inc(input logic [IW-1:0] p);
    return (p == IW'(NFR - 1)) ? '0 : p + 1'b1;
  endfunction

  // Input / packing side
  logic              armed;
  logic [SW-1:0]     samp_idx;
  logic [FW-1:0]     word_idx;
  logic              frame_ok;
  logic [WORD_W-1:0] frame_seq;
  logic [WORD_W-1:0] acc       [NCHAN];
  logic [WORD_W-1:0] next_word [NCHAN];
  logic [PW-1:0]     wr_ptr;
  logic [CNTW-1:0]   fill      [NCHAN];
  logic              ovf_flag;
  logic [15:0]       drops;

  // Storage
  logic [WORD_W-1:0] mem    [NCHAN][DEPTH];
  logic [WORD_W-1:0] id_mem [NFR];
  logic [IW-1:0]     id_wr;
  logic [IW-1:0]     id_rd;
  logic [RDYW-1:0]   frames_ready;

  // TX side
  tx_state_t         state;
  logic [CW-1:0]     ch;
  logic [FW-1:0]     w;
  logic [PW-1:0]     rd_ptr [NCHAN];
  logic              tx_valid;
  logic              tx_eod;
  logic [WORD_W-1:0] tx_data;

  logic capture, word_done, first_word, room, admit_now, wr_en, frame_done, id_push;
  logic hs, at_last, tx_start;
  logic [NCHAN-1:0] rd_en;

  always_comb begin
    room = 1'b1;
    for (int unsigned c = 0; c < NCHAN; c++) begin
      next_word[c] = (acc[c] << SAMPLE_W) | WORD_W'(bus.din[c*SAMPLE_W +: SAMPLE_W]);
      if (fill[c] > CNTW'(DEPTH - SPP)) room = 1'b0;
    end
  end

  // Admission is decided once at a frame's first word and then held for the whole frame.
  assign capture    = armed && bus.ce;
  assign word_done  = capture && (samp_idx == SW'(K - 1));
  assign first_word = (word_idx == '0);
  assign admit_now  = first_word ? room : frame_ok;
  assign wr_en      = word_done && admit_now;
  assign frame_done = wr_en && (word_idx == FW'(SPP - 1));
  assign id_push    = word_done && first_word && room;

  always_ff @(posedge clk) begin
    if (rst) begin
      armed     <= 1'b0;
      samp_idx  <= '0;
      word_idx  <= '0;
      frame_ok  <= 1'b0;
      frame_seq <= '0;
      wr_ptr    <= '0;
      id_wr     <= '0;
      ovf_flag  <= 1'b0;
      drops     <= '0;
      for (int unsigned c = 0; c < NCHAN; c++) acc[c] <= '0;
    end else if (bus.ce) begin
      if (!armed) begin
        armed <= bus.sync;
      end else begin
        for (int unsigned c = 0; c < NCHAN; c++) acc[c] <= next_word[c];
        samp_idx <= word_done ? '0 : samp_idx + 1'b1;
        if (word_done) begin
          if (first_word) begin
            frame_ok <= room;
            if (!room) begin
              ovf_flag <= 1'b1;
              if (drops != '1) drops <= drops + 1'b1;
            end
          end
          if (id_push) id_wr <= id_inc(id_wr);
          if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
          if (word_idx == FW'(SPP - 1)) begin
            word_idx  <= '0;
            frame_seq <= frame_seq + 1'b1;
          end else begin
            word_idx <= word_idx + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned c = 0; c < NCHAN; c++) mem[c][wr_ptr] <= next_word[c];
    end
    if (id_push) id_mem[id_wr] <= frame_seq;
  end

  assign hs       = tx_valid && bus.tx_ready;
  assign at_last  = (state == DATA) && (ch == CW'(NCHAN - 1)) && (w == FW'(SPP - 1));
  // Leaving IDLE and chaining straight from an eod handshake both consume a ready frame.
  assign tx_start = (frames_ready != '0) && ((state == IDLE) || (hs && at_last));

  always_comb begin
    rd_en = '0;
    if ((state == DATA) && hs) rd_en[ch] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frames_ready <= '0;
      for (int unsigned c = 0; c < NCHAN; c++) fill[c] <= '0;
    end else begin
      case ({frame_done, tx_start})
        2'b10:   frames_ready <= frames_ready + 1'b1;
        2'b01:   frames_ready <= frames_ready - 1'b1;
        default: ;
      endcase
      for (int unsigned c = 0; c < NCHAN; c++)
        fill[c] <= fill[c] + CNTW'(wr_en) - CNTW'(rd_en[c]);
    end
  end

  // TX FSM; all stream outputs are registered and only change on a handshake or packet start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_eod   <= 1'b0;
      tx_data  <= '0;
      ch       <= '0;
      w        <= '0;
      id_rd    <= '0;
      for (int unsigned c = 0; c < NCHAN; c++) rd_ptr[c] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frames_ready != '0) state <= HDR;
        end
        HDR: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= id_mem[id_rd];
          end else if (bus.tx_ready) begin
            state   <= DATA;
            ch      <= '0;
            w       <= '0;
            tx_data <= mem[0][rd_ptr[0]];
          end
        end
        DATA: begin
          if (bus.tx_ready) begin
            rd_ptr[ch] <= ptr_inc(rd_ptr[ch]);
            if (at_last) begin
              tx_eod <= 1'b0;
              id_rd  <= id_inc(id_rd);
              if (frames_ready != '0) begin
                state   <= HDR;
                tx_data <= id_mem[id_inc(id_rd)];
              end else begin
                state    <= IDLE;
                tx_valid <= 1'b0;
              end
            end else if (w == FW'(SPP - 1)) begin
              ch      <= ch + 1'b1;
              w       <= '0;
              tx_data <= mem[ch + 1'b1][rd_ptr[ch + 1'b1]];
              tx_eod  <= 1'b0;
            end else begin
              w       <= w + 1'b1;
              tx_data <= mem[ch][ptr_inc(rd_ptr[ch])];
              tx_eod  <= (ch == CW'(NCHAN - 1)) && (w == FW'(SPP - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_data    = tx_data;
  assign bus.tx_valid   = tx_valid;
  assign bus.tx_eod     = tx_eod;
  assign bus.overflow   = ovf_flag;
  assign bus.drop_count = drops;
endmodule

// File: tb/tb_chan_packetizer.sv
// Directed + randomized bench for chan_packetizer against a frame-level reference model.
module tb_chan_packetizer;
  localparam int NCHAN = 2;
  localparam int SW    = 16;
  localparam int WW    = 64;
  localparam int SPP   = 4;
  localparam int DEPTH = 8;
  localparam int K     = WW / SW;

  typedef struct {
    logic [63:0] data;
    bit          eod;
    int          ch;   // -1 marks a header
    int          rdy;  // edge index at which the frame became complete
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chan_packetizer_if #(.NCHAN(NCHAN), .SAMPLE_W(SW), .WORD_W(WW)) bus ();

  chan_packetizer #(
    .NCHAN(NCHAN), .SAMPLE_W(SW), .WORD_W(WW), .SPP(SPP), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  ent_t        exp_q [$];
  logic [63:0] obs   [$];
  bit          ramp;
  bit          armed_m;
  int          kcnt, wif, n_samp, drop_m, last_eod;
  bit          admit_m, ovf_m;
  logic [63:0] fid;
  logic [63:0] acc_m [NCHAN];
  logic [63:0] fw    [NCHAN][SPP];
  int          wr_m  [NCHAN];
  int          rd_m  [NCHAN];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic bit exp_valid();
    int st;
    if (exp_q.size() == 0) return 1'b0;
    if (exp_q[0].ch >= 0) return 1'b1;
    st = (exp_q[0].rdy < last_eod) ? last_eod : exp_q[0].rdy + 2;
    return cyc >= st;
  endfunction

  function automatic bit pick_rdy(input int pct);
    if (pct >= 100) return 1'b1;
    if (pct <= 0) return 1'b0;
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic model_edge(input bit r, input bit ce_i, input bit sync_i,
                            input logic [31:0] d, input bit hs);
    ent_t e;
    if (r) begin
      exp_q.delete();
      armed_m = 0; kcnt = 0; wif = 0; admit_m = 0; fid = '0;
      ovf_m = 0; drop_m = 0; n_samp = 0; last_eod = -100;
      for (int c = 0; c < NCHAN; c++) begin
        wr_m[c] = 0; rd_m[c] = 0; acc_m[c] = '0;
      end
      return;
    end
    if (ce_i) begin
      if (!armed_m) begin
        armed_m = sync_i;
      end else begin
        n_samp++;
        for (int c = 0; c < NCHAN; c++)
          acc_m[c] = (acc_m[c] << SW) | 64'(d[c*SW +: SW]);
        kcnt++;
        if (kcnt == K) begin
          kcnt = 0;
          if (wif == 0) begin
            admit_m = 1;
            for (int c = 0; c < NCHAN; c++)
              if (DEPTH - (wr_m[c] - rd_m[c]) < SPP) admit_m = 0;
            if (!admit_m) begin
              ovf_m = 1;
              if (drop_m < 65535) drop_m++;
            end
          end
          if (admit_m) begin
            for (int c = 0; c < NCHAN; c++) begin
              fw[c][wif] = acc_m[c];
              wr_m[c]++;
            end
          end
          wif++;
          if (wif == SPP) begin
            if (admit_m) begin
              exp_q.push_back('{data: fid, eod: 1'b0, ch: -1, rdy: cyc});
              for (int c = 0; c < NCHAN; c++)
                for (int i = 0; i < SPP; i++)
                  exp_q.push_back('{data: fw[c][i], eod: (c == NCHAN-1 && i == SPP-1),
                                    ch: c, rdy: cyc});
            end
            fid++;
            wif = 0;
          end
        end
      end
    end
    if (hs) begin
      e = exp_q.pop_front();
      if (e.ch >= 0) rd_m[e.ch]++;
      if (e.eod) last_eod = cyc;
    end
  endtask

  task automatic tick(input bit ce_i, input bit sync_i, input bit rdy_i, input bit rst_i);
    bit ev, hs;
    logic [31:0] d;
    rst          = rst_i;
    bus.ce       = ce_i;
    bus.sync     = sync_i;
    bus.tx_ready = rdy_i;
    if (ramp) bus.din = {16'(16'h100 + n_samp), 16'(n_samp)};
    else      bus.din = 32'($urandom);
    d  = bus.din;
    ev = exp_valid();
    chk("tx_valid", 64'(bus.tx_valid), 64'(ev));
    if (ev) begin
      chk("tx_data", bus.tx_data, exp_q[0].data);
      chk("tx_eod", 64'(bus.tx_eod), 64'(exp_q[0].eod));
    end
    chk("overflow", 64'(bus.overflow), 64'(ovf_m));
    chk("drop_count", 64'(bus.drop_count), 64'(drop_m));
    hs = ev && rdy_i;
    if (hs) obs.push_back(bus.tx_data);
    @(posedge clk);
    cyc++;
    model_edge(rst_i, ce_i, sync_i, d, hs);
    #1;
  endtask

  task automatic run(input int upto, input int ce_mode, input int rdy_pct,
                     input bit sync_spam, input bit arm);
    int k = 0;
    if (arm) tick(1'b1, 1'b1, pick_rdy(rdy_pct), 1'b0);
    while (n_samp < upto && k < 4000) begin
      bit ce_v;
      if (ce_mode == 0)      ce_v = ($urandom_range(0, 9) < 7);
      else if (ce_mode == 1) ce_v = 1'b1;
      else                   ce_v = ((k % ce_mode) == 0);
      tick(ce_v, sync_spam ? 1'($urandom_range(0, 1)) : 1'b0, pick_rdy(rdy_pct), 1'b0);
      k++;
    end
  endtask

  task automatic drain(input int rdy_pct);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++)
      tick(1'b0, 1'b0, pick_rdy(rdy_pct), 1'b0);
    repeat (4) tick(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    obs.delete();
  endtask

  task automatic check_ramp_pkts(input string t);
    chk({t, "_nwords"}, 64'(obs.size()), 64'd18);
    chk({t, "_hdr0"}, obs[0], 64'd0);
    chk({t, "_c0w0"}, obs[1], 64'h0000_0001_0002_0003);
    chk({t, "_c1w0"}, obs[5], 64'h0100_0101_0102_0103);
    chk({t, "_hdr1"}, obs[9], 64'd1);
    chk({t, "_p1c0w0"}, obs[10], 64'h0010_0011_0012_0013);
    chk({t, "_p1last"}, obs[17], 64'h011C_011D_011E_011F);
  endtask

  initial begin
    rst = 1'b1; bus.ce = 1'b0; bus.sync = 1'b0; bus.din = '0; bus.tx_ready = 1'b1;
    ramp = 1'b1;
    model_edge(1'b1, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    do_reset();
    chk("rst_valid", 64'(bus.tx_valid), 64'd0);
    chk("rst_eod", 64'(bus.tx_eod), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    chk("rst_drops", 64'(bus.drop_count), 64'd0);

    // 1: continuous ramp, full throughput
    run(32, 1, 100, 1'b0, 1'b1);
    drain(100);
    check_ramp_pkts("t1");

    // 2: random backpressure
    do_reset();
    run(32, 1, 50, 1'b0, 1'b1);
    drain(50);
    check_ramp_pkts("t2");

    // 3: stalled sink forces frame drops
    do_reset();
    run(80, 1, 0, 1'b0, 1'b1);
    chk("t3_ovf", 64'(bus.overflow), 64'd1);
    chk("t3_drops", 64'(bus.drop_count), 64'd3);
    run(128, 1, 100, 1'b0, 1'b0);
    drain(100);
    chk("t3_hdr0", obs[0], 64'd0);
    chk("t3_hdr1", obs[9], 64'd1);
    chk("t3_gap", 64'(obs[18] >= 64'd5), 64'd1);

    // 4: ce one cycle in three
    do_reset();
    run(32, 3, 100, 1'b0, 1'b1);
    drain(100);
    check_ramp_pkts("t4");

    // 5: reset mid-DATA after an overflow
    do_reset();
    run(48, 1, 0, 1'b0, 1'b1);
    repeat (4) tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_busy", 64'(bus.tx_valid), 64'd1);
    do_reset();
    chk("t5_valid", 64'(bus.tx_valid), 64'd0);
    chk("t5_eod", 64'(bus.tx_eod), 64'd0);
    chk("t5_ovf", 64'(bus.overflow), 64'd0);
    chk("t5_drops", 64'(bus.drop_count), 64'd0);
    run(16, 1, 100, 1'b0, 1'b1);
    drain(100);
    chk("t5_hdr0", obs[0], 64'd0);
    chk("t5_c0w0", obs[1], 64'h0000_0001_0002_0003);

    // 6: sync toggling while armed
    do_reset();
    run(32, 1, 100, 1'b1, 1'b1);
    drain(100);
    check_ramp_pkts("t6");

    // 7: random data, random ce, random backpressure
    do_reset();
    ramp = 1'b0;
    run(160, 0, 60, 1'b1, 1'b1);
    drain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
